// File: rtl/key_entry.sv
// key_entry: PS/2 set-2 hex key entry buffer with mode select and Enter commit.
// Build option KEY_ENTRY_PARTIAL_EN: allow committing a partially filled buffer.
module key_entry (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         scan_valid,
    input  logic [7:0]   scan_code,
    output logic [127:0] keyboard,
    output logic         Enter,
    output logic [1:0]   Option,
    output logic [5:0]   digit_count,
    output logic         entry_full
);
    typedef enum logic [1:0] {MAKE, BREAK, EXT} state_t;
    state_t state, state_nx;
    logic [127:0] kb_base, kb_nx;
    logic [5:0] cnt_base, cnt_nx;
    logic [1:0] opt_nx;
    logic enter_nx, make, is_hex, can_commit;
    logic [3:0] nibble;
    always_comb begin
        is_hex = 1'b1;
        nibble = 4'h0;
        case (scan_code)
            8'h45: nibble = 4'h0;
            8'h16: nibble = 4'h1;
            8'h1E: nibble = 4'h2;
            8'h26: nibble = 4'h3;
            8'h25: nibble = 4'h4;
            8'h2E: nibble = 4'h5;
            8'h36: nibble = 4'h6;
            8'h3D: nibble = 4'h7;
            8'h3E: nibble = 4'h8;
            8'h46: nibble = 4'h9;
            8'h1C: nibble = 4'hA;
            8'h32: nibble = 4'hB;
            8'h21: nibble = 4'hC;
            8'h23: nibble = 4'hD;
            8'h24: nibble = 4'hE;
            8'h2B: nibble = 4'hF;
            default: is_hex = 1'b0;
        endcase
    end
    // The buffer clears on the edge after the Enter pulse; any byte in that
    // cycle is applied on top of the cleared buffer.
    assign kb_base  = Enter ? '0 : keyboard;
    assign cnt_base = Enter ? '0 : digit_count;
`ifdef KEY_ENTRY_PARTIAL_EN
    assign can_commit = cnt_base != 6'd0;
`else
    assign can_commit = cnt_base == 6'd32;
`endif
    always_comb begin
        state_nx = state;
        kb_nx    = kb_base;
        cnt_nx   = cnt_base;
        opt_nx   = Option;
        enter_nx = 1'b0;
        make     = 1'b0;
        if (scan_valid) begin
            case (state)
                MAKE: begin
                    state_nx = scan_code == 8'hF0 ? BREAK : scan_code == 8'hE0 ? EXT : MAKE;
                    make     = scan_code != 8'hF0 && scan_code != 8'hE0;
                end
                BREAK:   state_nx = MAKE;
                default: state_nx = scan_code == 8'hF0 ? BREAK : MAKE;
            endcase
        end
        if (make) begin
            if (is_hex) begin
                if (cnt_base != 6'd32) begin
                    kb_nx  = {kb_base[123:0], nibble};
                    cnt_nx = cnt_base + 6'd1;
                end
            end else begin
                case (scan_code)
                    8'h66: if (cnt_base != 6'd0) begin
                        kb_nx  = {4'h0, kb_base[127:4]};
                        cnt_nx = cnt_base - 6'd1;
                    end
                    8'h05: opt_nx = 2'b00;
                    8'h06: opt_nx = 2'b01;
                    8'h76: begin
                        opt_nx = 2'b10;
                        kb_nx  = '0;
                        cnt_nx = '0;
                    end
                    8'h5A: enter_nx = !Option[1] && can_commit;
                    default: ;
                endcase
            end
        end
    end
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= MAKE;
            keyboard    <= '0;
            digit_count <= '0;
            Option      <= 2'b11;
            Enter       <= 1'b0;
        end else begin
            state       <= state_nx;
            keyboard    <= kb_nx;
            digit_count <= cnt_nx;
            Option      <= opt_nx;
            Enter       <= enter_nx;
        end
    end
    assign entry_full = digit_count == 6'd32;
endmodule

// File: tb/tb_key_entry.sv
// tb_key_entry: randomized and directed checks of key_entry against a digit-queue model.
module tb_key_entry;
    logic Clk = 1'b0, Reset = 1'b0, scan_valid = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic [127:0] keyboard;
    logic Enter, entry_full;
    logic [1:0] Option;
    logic [5:0] digit_count;

    key_entry dut (
        .Clk(Clk), .Reset(Reset), .scan_valid(scan_valid), .scan_code(scan_code),
        .keyboard(keyboard), .Enter(Enter), .Option(Option),
        .digit_count(digit_count), .entry_full(entry_full)
    );

    always #5 Clk = ~Clk;

`ifdef KEY_ENTRY_PARTIAL_EN
    localparam int MIN_DIGITS = 1;
`else
    localparam int MIN_DIGITS = 32;
`endif

    int n_cmp = 0, n_bad = 0;
    logic [7:0] hex_codes [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
    // Model: digits entered, oldest first; keyboard is their concatenation.
    logic [3:0] q [$];
    logic [1:0] m_opt = 2'b11;
    bit m_skip, m_ext, m_pulse;

    function automatic int hex_of(input logic [7:0] b);
        for (int i = 0; i < 16; i++) if (hex_codes[i] == b) return i;
        return -1;
    endfunction

    function automatic logic [127:0] exp_kb();
        logic [127:0] k = '0;
        foreach (q[i]) k = {k[123:0], q[i]};
        return k;
    endfunction

    function automatic void model_make(input logic [7:0] b);
        int h = hex_of(b);
        if (h >= 0) begin
            if (q.size() < 32) q.push_back(h[3:0]);
        end else begin
            case (b)
                8'h66: if (q.size() > 0) void'(q.pop_back());
                8'h05: m_opt = 2'b00;
                8'h06: m_opt = 2'b01;
                8'h76: begin m_opt = 2'b10; q.delete(); end
                8'h5A: if (m_opt < 2 && q.size() >= MIN_DIGITS) m_pulse = 1;
                default: ;
            endcase
        end
    endfunction

    function automatic void model_cycle(input bit v, input logic [7:0] b);
        if (m_pulse) begin q.delete(); m_pulse = 0; end
        if (v) begin
            if (m_skip) m_skip = 0;
            else if (m_ext) begin m_ext = 0; m_skip = (b == 8'hF0); end
            else if (b == 8'hF0) m_skip = 1;
            else if (b == 8'hE0) m_ext = 1;
            else model_make(b);
        end
    endfunction

    task automatic tick(input bit v, input logic [7:0] b);
        scan_valid = v;
        scan_code = b;
        @(posedge Clk);
        model_cycle(v, b);
        @(negedge Clk);
        scan_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, b);
    endtask

    task automatic press(input logic [7:0] b);
        send(b); send(8'hF0); send(b);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        q.delete(); m_opt = 2'b11; m_skip = 0; m_ext = 0; m_pulse = 0;
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        n_cmp++; if (keyboard !== 128'h0) begin n_bad++; $display("FAIL reset_kb: got %h expected 0", keyboard); end
        n_cmp++; if (digit_count !== 6'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d expected 0", digit_count); end
        n_cmp++; if (entry_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b expected 0", entry_full); end
        n_cmp++; if (Enter !== 1'b0) begin n_bad++; $display("FAIL reset_enter: got %b expected 0", Enter); end
        n_cmp++; if (Option !== 2'b11) begin n_bad++; $display("FAIL reset_opt: got %b expected 11", Option); end
        Reset = 1'b1;
    endtask

    task automatic test_fill_commit();
        do_reset();
        send(8'h05);
        repeat (32) press(8'h16);
        n_cmp++; if (digit_count !== 6'd32 || entry_full !== 1'b1) begin n_bad++; $display("FAIL fill_cnt: got %0d/%b expected 32/1", digit_count, entry_full); end
        send(8'h5A);
        n_cmp++; if (Enter !== 1'b1) begin n_bad++; $display("FAIL fill_pulse: got %b expected 1", Enter); end
        n_cmp++; if (keyboard !== {32{4'h1}}) begin n_bad++; $display("FAIL fill_kb_pulse: got %h expected %h", keyboard, {32{4'h1}}); end
        tick(1'b0, 8'h00);
        n_cmp++; if (Enter !== 1'b0) begin n_bad++; $display("FAIL fill_pulse_end: got %b expected 0", Enter); end
        n_cmp++; if (keyboard !== 128'h0 || digit_count !== 6'd0) begin n_bad++; $display("FAIL fill_clear: got %h/%0d expected 0/0", keyboard, digit_count); end
        n_cmp++; if (Option !== 2'b00) begin n_bad++; $display("FAIL fill_opt: got %b expected 00", Option); end
        send(8'hF0); send(8'h5A);
    endtask

    task automatic test_backspace();
        do_reset();
        send(8'h06);
        press(8'h1C); press(8'h32); press(8'h21); press(8'h66);
        n_cmp++; if (keyboard !== 128'hAB) begin n_bad++; $display("FAIL bs_kb: got %h expected ab", keyboard); end
        n_cmp++; if (digit_count !== 6'd2) begin n_bad++; $display("FAIL bs_cnt: got %0d expected 2", digit_count); end
        n_cmp++; if (Option !== 2'b01) begin n_bad++; $display("FAIL bs_opt: got %b expected 01", Option); end
        repeat (3) press(8'h66);
        n_cmp++; if (keyboard !== 128'h0 || digit_count !== 6'd0) begin n_bad++; $display("FAIL bs_empty: got %h/%0d expected 0/0", keyboard, digit_count); end
    endtask

    task automatic test_full();
        logic [127:0] snap;
        do_reset();
        send(8'h05);
        repeat (32) press(hex_codes[$urandom_range(0, 15)]);
        snap = exp_kb();
        press(8'h2B);
        n_cmp++; if (keyboard !== snap) begin n_bad++; $display("FAIL full_kb: got %h expected %h", keyboard, snap); end
        n_cmp++; if (entry_full !== 1'b1 || digit_count !== 6'd32) begin n_bad++; $display("FAIL full_flag: got %b/%0d expected 1/32", entry_full, digit_count); end
        send(8'h5A);
        n_cmp++; if (Enter !== 1'b1) begin n_bad++; $display("FAIL full_pulse: got %b expected 1", Enter); end
        tick(1'b0, 8'h00);
    endtask

    task automatic test_break_ext();
        logic [7:0] seq [7] = '{8'hF0, 8'h5A, 8'hE0, 8'hF0, 8'h45, 8'hE0, 8'h75};
        bit pulsed = 0;
        do_reset();
        send(8'h05);
        press(8'h1E);
        foreach (seq[i]) begin send(seq[i]); pulsed |= Enter; end
        n_cmp++; if (pulsed) begin n_bad++; $display("FAIL brk_pulse: got 1 expected 0"); end
        n_cmp++; if (digit_count !== 6'd1 || keyboard !== 128'h2) begin n_bad++; $display("FAIL brk_kb: got %h/%0d expected 2/1", keyboard, digit_count); end
        send(8'h26);
        n_cmp++; if (keyboard !== 128'h23) begin n_bad++; $display("FAIL brk_make: got %h expected 23", keyboard); end
        send(8'hF0);
        do_reset();
        send(8'h16);
        n_cmp++; if (keyboard !== 128'h1 || digit_count !== 6'd1) begin n_bad++; $display("FAIL brk_reset: got %h/%0d expected 1/1", keyboard, digit_count); end
    endtask

    task automatic test_partial();
        bit acc = (MIN_DIGITS <= 3);
        do_reset();
        send(8'h05);
        press(8'h3E); press(8'h46); press(8'h1C);
        send(8'h5A);
        n_cmp++; if (Enter !== acc) begin n_bad++; $display("FAIL part_pulse: got %b expected %b", Enter, acc); end
        n_cmp++; if (keyboard !== 128'h89A) begin n_bad++; $display("FAIL part_kb: got %h expected 89a", keyboard); end
        tick(1'b0, 8'h00);
        n_cmp++; if (digit_count !== (acc ? 6'd0 : 6'd3)) begin n_bad++; $display("FAIL part_cnt: got %0d expected %0d", digit_count, acc ? 0 : 3); end
    endtask

    task automatic test_reset_pending();
        do_reset();
        send(8'h05);
        repeat (32) press(8'h16);
        scan_valid = 1'b1;
        scan_code = 8'h5A;
        @(posedge Clk);
        #1 Reset = 1'b0;
        scan_valid = 1'b0;
        q.delete(); m_opt = 2'b11; m_skip = 0; m_ext = 0; m_pulse = 0;
        @(negedge Clk);
        n_cmp++; if (Enter !== 1'b0) begin n_bad++; $display("FAIL rp_pulse: got %b expected 0", Enter); end
        n_cmp++; if (Option !== 2'b11 || digit_count !== 6'd0) begin n_bad++; $display("FAIL rp_state: got %b/%0d expected 11/0", Option, digit_count); end
        Reset = 1'b1;
        tick(1'b0, 8'h00);
        n_cmp++; if (Enter !== 1'b0) begin n_bad++; $display("FAIL rp_late: got %b expected 0", Enter); end
        press(8'h16); press(8'h32);
        send(8'h76);
        n_cmp++; if (Option !== 2'b10 || keyboard !== 128'h0 || digit_count !== 6'd0 || Enter !== 1'b0) begin
            n_bad++; $display("FAIL rp_esc: got %b/%h/%0d/%b expected 10/0/0/0", Option, keyboard, digit_count, Enter);
        end
    endtask

    task automatic test_back_to_back();
        bit e1, e2, e3;
        do_reset();
        send(8'h05);
        repeat (32) send(8'h16);
        send(8'h5A); e1 = Enter;
        send(8'h5A); e2 = Enter;
        send(8'h5A); e3 = Enter;
        n_cmp++; if ({e1, e2, e3} !== 3'b100) begin n_bad++; $display("FAIL b2b_pulses: got %b expected 100", {e1, e2, e3}); end
        n_cmp++; if (digit_count !== 6'd0) begin n_bad++; $display("FAIL b2b_cnt: got %0d expected 0", digit_count); end
    endtask

    task automatic test_random();
        bit prev = 0;
        logic [7:0] b;
        int r;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            b = r < 55 ? hex_codes[$urandom_range(0, 15)] : r < 63 ? 8'hF0 : r < 66 ? 8'hE0 :
                r < 74 ? 8'h66 : r < 79 ? 8'h05 : r < 83 ? 8'h06 : r < 85 ? 8'h76 :
                r < 95 ? 8'h5A : 8'($urandom);
            tick($urandom_range(0, 3) != 0, b);
            n_cmp++; if (keyboard !== exp_kb()) begin n_bad++; $display("FAIL rnd_kb[%0d]: got %h expected %h", i, keyboard, exp_kb()); end
            n_cmp++; if (digit_count !== 6'(q.size())) begin n_bad++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", i, digit_count, q.size()); end
            n_cmp++; if (entry_full !== (q.size() == 32)) begin n_bad++; $display("FAIL rnd_full[%0d]: got %b expected %b", i, entry_full, q.size() == 32); end
            n_cmp++; if (Enter !== m_pulse) begin n_bad++; $display("FAIL rnd_enter[%0d]: got %b expected %b", i, Enter, m_pulse); end
            n_cmp++; if (Option !== m_opt) begin n_bad++; $display("FAIL rnd_opt[%0d]: got %b expected %b", i, Option, m_opt); end
            n_cmp++; if (prev && Enter) begin n_bad++; $display("FAIL rnd_double[%0d]: got 11 expected no consecutive pulses", i); end
            prev = Enter;
        end
    endtask

    initial begin
        test_reset();
        test_fill_commit();
        test_backspace();
        test_full();
        test_break_ext();
        test_partial();
        test_reset_pending();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
